// File: rtl/stage_3.sv
// stage_3: AV1 range-coder back end -- folds up to two symbols per cycle into low/cnt, emits pre-carry words and flushes.
// Optional S3_OUT_REG_EN: re-registers out_word_1/2, out_flag and flush_done once more (output latency 2).
module stage_3 #(
   parameter int RANGE_WIDTH = 16,
   parameter int D_SIZE      = 5,
   parameter int LOW_WIDTH   = 32,
   parameter int WORD_WIDTH  = 9
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic                   flush,
   input  logic [RANGE_WIDTH:0]   u,
   input  logic [RANGE_WIDTH-1:0] initial_range_1,
   input  logic [RANGE_WIDTH-1:0] pre_low_1,
   input  logic [RANGE_WIDTH-1:0] pre_low_2,
   input  logic [D_SIZE-1:0]      d_1,
   input  logic [D_SIZE-1:0]      d_2,
   input  logic                   bool_1,
   input  logic                   bool_2,
   input  logic                   symbol_1,
   input  logic                   symbol_2,
   input  logic                   COMP_mux_1,
   output logic                   in_ready,
   output logic [WORD_WIDTH-1:0]  out_word_1,
   output logic [WORD_WIDTH-1:0]  out_word_2,
   output logic [1:0]             out_flag,
   output logic                   flush_done
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic signed [5:0]     CNT_INIT = -6'sd9;
   localparam logic [LOW_WIDTH-1:0]  ONE      = LOW_WIDTH'(1);
   localparam logic [LOW_WIDTH-1:0]  FL_MASK  = LOW_WIDTH'(14'h3FFF);

   typedef struct packed {
      logic [LOW_WIDTH-1:0]  low;
      logic signed [7:0]     cnt;
      logic [1:0]            n;
      logic [WORD_WIDTH-1:0] w1;
      logic [WORD_WIDTH-1:0] w2;
   } step_t;

   // One od_ec normalisation step: add to low, shift by d, peel off any completed bytes.
   function automatic step_t enc_step(input logic [LOW_WIDTH-1:0] low_in,
                                      input logic signed [7:0]    cnt_in,
                                      input logic [LOW_WIDTH-1:0] add,
                                      input logic [D_SIZE-1:0]    d);
      step_t                r;
      logic [LOW_WIDTH-1:0] l;
      logic [LOW_WIDTH-1:0] m;
      logic signed [7:0]    dd;
      logic signed [7:0]    s;
      logic signed [7:0]    c;
      r  = '0;
      dd = $signed({{(8-D_SIZE){1'b0}}, d});
      l  = low_in + add;
      s  = cnt_in + dd;
      c  = '0;
      m  = '0;
      if (s >= 8'sd0) begin
         c = cnt_in + 8'sd16;
         m = (ONE << c[5:0]) - ONE;
         if (s >= 8'sd8) begin
            r.w1 = WORD_WIDTH'(l >> c[5:0]);
            r.n  = 2'd1;
            l    = l & m;
            c    = c - 8'sd8;
            m    = m >> 8;
         end
         if (r.n == 2'd0) r.w1 = WORD_WIDTH'(l >> c[5:0]);
         else             r.w2 = WORD_WIDTH'(l >> c[5:0]);
         r.n = r.n + 2'd1;
         l   = l & m;
         s   = c + dd - 8'sd24;
      end
      r.low = l << d;
      r.cnt = s;
      return r;
   endfunction

   logic [1:0]              state, state_d;
   logic [LOW_WIDTH-1:0]    low, low_d;
   logic signed [5:0]       cnt, cnt_d;
   logic [LOW_WIDTH-1:0]    fl_e, fe_d, fl_n, fn_d;
   logic signed [7:0]       fl_s, fs_d, fl_c, fc_d, fl_sh;
   logic [1:0]              flag_q, flag_d;
   logic [WORD_WIDTH-1:0]   w1_q, w1_d, w2_q, w2_d;
   logic                    done_q, done_d;

   logic [RANGE_WIDTH-1:0]  cdf_add;
   logic [LOW_WIDTH-1:0]    add_1, add_2, nxt_low;
   logic signed [7:0]       cnt_ext, nxt_cnt, ent_sh;
   logic                    pair;
   step_t                   st_1, st_2;
   logic                    unused_u_msb;

   assign unused_u_msb = u[RANGE_WIDTH];
   assign cdf_add      = initial_range_1 - u[RANGE_WIDTH-1:0];
   assign add_1        = bool_1 ? (symbol_1 ? LOW_WIDTH'(pre_low_1) : '0)
                                : (COMP_mux_1 ? LOW_WIDTH'(cdf_add) : '0);
   assign add_2        = symbol_2 ? LOW_WIDTH'(pre_low_2) : '0;
   assign pair         = bool_1 & bool_2;
   assign cnt_ext      = $signed({{2{cnt[5]}}, cnt});
   assign fl_sh        = fl_c + 8'sd16;

   // Second bool is chained combinationally onto the first symbol's result.
   assign st_1 = enc_step(low, cnt_ext, add_1, d_1);
   assign st_2 = enc_step(st_1.low, st_1.cnt, add_2, d_2);

   assign in_ready = (state == ST_RUN);

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d = state;
      low_d   = low;
      cnt_d   = cnt;
      fe_d    = fl_e;
      fs_d    = fl_s;
      fc_d    = fl_c;
      fn_d    = fl_n;
      flag_d  = 2'd0;
      w1_d    = '0;
      w2_d    = '0;
      done_d  = 1'b0;
      nxt_low = low;
      nxt_cnt = cnt_ext;
      ent_sh  = '0;
      case (state)
         ST_RUN: begin
            if (in_valid) begin
               if (!pair) begin
                  nxt_low = st_1.low;  nxt_cnt = st_1.cnt;
                  flag_d  = st_1.n;    w1_d = st_1.w1;  w2_d = st_1.w2;
               end else begin
                  nxt_low = st_2.low;  nxt_cnt = st_2.cnt;
                  if (st_1.n == 2'd0) begin
                     flag_d = st_2.n;  w1_d = st_2.w1;  w2_d = st_2.w2;
                  end else if (st_2.n == 2'd0) begin
                     flag_d = st_1.n;  w1_d = st_1.w1;  w2_d = st_1.w2;
                  end else begin
                     flag_d = 2'd2;    w1_d = st_1.w1;  w2_d = st_2.w1;
                  end
               end
            end
            low_d = nxt_low;
            cnt_d = nxt_cnt[5:0];
            // Flush starts from low/cnt after any symbol accepted in the same cycle.
            if (flush) begin
               state_d = ST_FLUSH;
               ent_sh  = nxt_cnt + 8'sd16;
               fe_d    = ((nxt_low + FL_MASK) & ~FL_MASK) | (FL_MASK + ONE);
               fs_d    = nxt_cnt + 8'sd10;
               fc_d    = nxt_cnt;
               fn_d    = (ONE << ent_sh[5:0]) - ONE;
            end
         end
         ST_FLUSH: begin
            if (fl_s > 8'sd0) begin
               flag_d = 2'd1;
               w1_d   = WORD_WIDTH'(fl_e >> fl_sh[5:0]);
               fe_d   = fl_e & fl_n;
               fs_d   = fl_s - 8'sd8;
               fc_d   = fl_c - 8'sd8;
               fn_d   = fl_n >> 8;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            low_d   = '0;
            cnt_d   = CNT_INIT;
            state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_RUN;
         low    <= '0;
         cnt    <= CNT_INIT;
         fl_e   <= '0;
         fl_n   <= '0;
         fl_s   <= '0;
         fl_c   <= '0;
         flag_q <= 2'd0;
         w1_q   <= '0;
         w2_q   <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_d;
         low    <= low_d;
         cnt    <= cnt_d;
         fl_e   <= fe_d;
         fl_n   <= fn_d;
         fl_s   <= fs_d;
         fl_c   <= fc_d;
         flag_q <= flag_d;
         w1_q   <= w1_d;
         w2_q   <= w2_d;
         done_q <= done_d;
      end
   end

`ifdef S3_OUT_REG_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_flag   <= 2'd0;
         out_word_1 <= '0;
         out_word_2 <= '0;
         flush_done <= 1'b0;
      end else begin
         out_flag   <= flag_q;
         out_word_1 <= w1_q;
         out_word_2 <= w2_q;
         flush_done <= done_q;
      end
   end
`else
   assign out_flag   = flag_q;
   assign out_word_1 = w1_q;
   assign out_word_2 = w2_q;
   assign flush_done = done_q;
`endif

endmodule
